// File: rtl/lt100_dma_if.sv
// Little Timmy 100 common-bus signals between a bus master (DMA) and the bus/slave side.
// Enable/ready handshake: master holds enable with stable fields until ready.
interface lt100_dma_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    m_enable;
    logic                    m_wr_en;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic                    m_bus_err;

    modport master (
        output m_enable, m_wr_en, m_addr, m_wdata, m_be,
        input  m_ready, m_rdata, m_bus_err
    );

    modport slave (
        input  m_enable, m_wr_en, m_addr, m_wdata, m_be,
        output m_ready, m_rdata, m_bus_err
    );
endinterface

// File: rtl/lt100_dma.sv
// Word-copy DMA initiator for the LT100 common bus: read src, write dst, len times.
// Optional completion interrupt when DMA_IRQ_EN is defined; otherwise irq is tied low.
module lt100_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  irq,
    lt100_dma_if.master           bus
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RGAP = 3'd2,
        WR   = 3'd3,
        WGAP = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic accept;
    logic rd_hs;
    logic wr_hs;

    assign accept = (state == IDLE) && start;
    assign rd_hs  = (state == RD) && bus.m_ready;
    assign wr_hs  = (state == WR) && bus.m_ready;

    // Bus outputs decode straight from state so an async reset drops enable at once.
    always_comb begin
        state_nxt    = state;
        bus.m_enable = 1'b0;
        bus.m_wr_en  = 1'b0;
        bus.m_addr   = src_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? FIN : RD;
                end
            end
            RD: begin
                bus.m_enable = 1'b1;
                bus.m_addr   = src_q;
                if (bus.m_ready) begin
                    state_nxt = bus.m_bus_err ? FIN : RGAP;
                end
            end
            RGAP: state_nxt = WR;
            WR: begin
                bus.m_enable = 1'b1;
                bus.m_wr_en  = 1'b1;
                bus.m_addr   = dst_q;
                if (bus.m_ready) begin
                    state_nxt = bus.m_bus_err ? FIN : WGAP;
                end
            end
            WGAP: state_nxt = (count_q == '0) ? FIN : RD;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.m_wdata = data_q;
    assign bus.m_be    = '1;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                err_q <= 1'b0;
            end else if ((rd_hs || wr_hs) && bus.m_bus_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // A failed access leaves the pointers and captured data untouched; the copy ends there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                count_q <= len;
            end
            if (rd_hs && !bus.m_bus_err) begin
                data_q <= bus.m_rdata;
            end
            if (wr_hs && !bus.m_bus_err) begin
                src_q   <= src_q + STEP;
                dst_q   <= dst_q + STEP;
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (accept) begin
            irq_q <= 1'b0;
        end else if (state == FIN) begin
            irq_q <= 1'b1;
        end
    end

    // FIN term lets irq rise together with done rather than a cycle later.
    assign irq = irq_q || (state == FIN);
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_lt100_dma.sv
// Randomized scoreboard bench for lt100_dma: a memory slave on the bus, a word-level copy
// model predicting writes and done/err, and a monitor comparing what the DUT does.
module tb_lt100_dma;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic          irq;

    lt100_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lt100_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .irq      (irq),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- environment: memory contents and error region ----------------
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a >= 32'h3000_0004) && (a <= 32'h3000_FFFF);
    endfunction

    function automatic logic [31:0] slave_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // ---------------- reference model: whole-copy prediction ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wq[$];
    bit  exp_dq[$];

    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        bit          e;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] v;
        wr_t         w;
        e = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            ra = s + 32'(4 * i);
            if (is_err(ra)) begin
                e = 1'b1;
                break;
            end
            v  = ref_read(ra);
            wa = d + 32'(4 * i);
            w.addr = wa;
            w.data = v;
            exp_wq.push_back(w);
            ref_mem[wa] = v;
        end
        exp_dq.push_back(e);
    endtask

    // ---------------- bus slave: random latency, one-cycle ready ----------------
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_wr;
    logic        cap_err;
    int          lat;

    initial begin
        bus.m_ready   = 1'b0;
        bus.m_bus_err = 1'b0;
        bus.m_rdata   = '0;
        lat           = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_ready) begin
                if (!rst && cap_wr && !cap_err) mem[cap_addr] = cap_wdata;
                bus.m_ready   = 1'b0;
                bus.m_bus_err = 1'b0;
                lat           = int'($urandom_range(0, 2));
            end else if (bus.m_enable) begin
                if (lat == 0) begin
                    cap_addr      = bus.m_addr;
                    cap_wr        = bus.m_wr_en;
                    cap_wdata     = bus.m_wdata;
                    cap_err       = !cap_wr && is_err(cap_addr);
                    bus.m_bus_err = cap_err;
                    bus.m_rdata   = cap_wr ? 32'h0 : (cap_err ? $urandom : slave_read(cap_addr));
                    bus.m_ready   = 1'b1;
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- monitor: pops expectations as the DUT acts ----------------
    bit prev_hs = 1'b0;
    bit prev_en = 1'b0;
    int en_pulses = 0;

    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hs = 1'b0;
                prev_en = 1'b0;
            end else begin
                if (prev_hs) check("enable_gap", 32'(bus.m_enable), 32'h0);
                if (bus.m_enable && !prev_en) en_pulses++;
                if (bus.m_enable && bus.m_ready) begin
                    check("byte_enables", 32'(bus.m_be), 32'hF);
                    if (bus.m_wr_en) begin
                        if (exp_wq.size() == 0) begin
                            fail_now("unexpected_write");
                        end else begin
                            w = exp_wq.pop_front();
                            check("wr_addr", bus.m_addr, w.addr);
                            check("wr_data", bus.m_wdata, w.data);
                        end
                    end
                end
                if (done) begin
                    if (exp_dq.size() == 0) fail_now("unexpected_done");
                    else check("done_err", 32'(err), 32'(exp_dq.pop_front()));
                end
                prev_hs = bus.m_enable && bus.m_ready;
                prev_en = bus.m_enable;
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_cyc;

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit poke_busy);
        int cyc;
        model_copy(s, d, n);
        en_pulses = 0;
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = 16'($urandom);
        check("busy_after_start", 32'(busy), 32'h1);
        check("err_cleared", 32'(err), 32'h0);
        if (n != 0) check("irq_cleared", 32'(irq), 32'h0);
        if (poke_busy) begin
            repeat (2) @(negedge clk);
            start    = 1'b1;
            src_addr = 32'h0000_0800;
            dst_addr = 32'h0000_0900;
            len      = 16'd9;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        last_cyc = cyc;
        if (cyc >= 400) fail_now("done_timeout");
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'h0);
        check("done_is_pulse", 32'(done), 32'h0);
`ifdef DMA_IRQ_EN
        check("irq_held", 32'(irq), 32'h1);
`else
        check("irq_tied_low", 32'(irq), 32'h0);
`endif
        check("writes_drained", 32'(exp_wq.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] d;
        logic [15:0] n;
        int          cyc;

        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_enable", 32'(bus.m_enable), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_done", 32'(done), 32'h0);
        check("idle_err", 32'(err), 32'h0);
        check("idle_irq", 32'(irq), 32'h0);
        check("idle_enable", 32'(bus.m_enable), 32'h0);
        check("idle_wr_en", 32'(bus.m_wr_en), 32'h0);
        check("idle_addr", bus.m_addr, 32'h0);
        check("idle_wdata", bus.m_wdata, 32'h0);

        // Four-word directed copy
        for (int i = 0; i < 4; i++) begin
            mem[32'(4 * i)]     = 32'(i + 1);
            ref_mem[32'(4 * i)] = 32'(i + 1);
        end
        run_copy(32'h0, 32'h100, 16'd4, 1'b0);
        check("copy4_enable_pulses", 32'(en_pulses), 32'd8);
        for (int i = 0; i < 4; i++) check("copy4_ram", slave_read(32'h100 + 32'(4 * i)), 32'(i + 1));
        check("copy4_err", 32'(err), 32'h0);

        // Zero-length copy
        run_copy(32'h40, 32'h140, 16'd0, 1'b0);
        check("len0_enable_pulses", 32'(en_pulses), 32'd0);
        check("len0_done_latency_ok", 32'(last_cyc <= 2), 32'h1);

        // Error on the second read
        run_copy(32'h3000_0000, 32'h200, 16'd3, 1'b0);
        check("err_flag", 32'(err), 32'h1);
        check("err_enable_pulses", 32'(en_pulses), 32'd3);

        // Start pulsed while busy must be ignored; also clears err from before
        run_copy(32'h0, 32'h300, 16'd4, 1'b1);
        check("poke_enable_pulses", 32'(en_pulses), 32'd8);

        // Randomized copies including address wrap and error-region sources
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: s = 32'hFFFF_FFF0;
                1: s = 32'h2FFF_FFF8;
                default: s = 32'h0000_0000 + 32'(4 * $urandom_range(0, 31));
            endcase
            d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8
                                            : 32'h0000_0040 + 32'(4 * $urandom_range(0, 31));
            n = 16'($urandom_range(0, 6));
            run_copy(s, d, n, 1'b0);
        end

        // Reset during a write access
        model_copy(32'h0, 32'h400, 16'd4);
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'h0;
        dst_addr = 32'h400;
        len      = 16'd4;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.m_enable && bus.m_wr_en) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) fail_now("wr_phase_timeout");
        rst = 1'b1;
        #1;
        check("rst_mid_wr_enable", 32'(bus.m_enable), 32'h0);
        check("rst_mid_wr_irq", 32'(irq), 32'h0);
        check("rst_mid_wr_busy", 32'(busy), 32'h0);
        exp_wq.delete();
        exp_dq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("after_rst_done", 32'(done), 32'h0);
        check("after_rst_enable", 32'(bus.m_enable), 32'h0);
        check("after_rst_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

endmodule
